// File: rtl/cd_period_meter_pkg.sv
// ============================================================================
// cd_period_meter_pkg : shared CD parameters and period-meter FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package cd_period_meter_pkg;

  localparam int CLK_MAX_WIDTH  = 16;
  localparam int CD_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } cd_state_e;

endpackage

`default_nettype wire

// File: rtl/cd_edge_sync.sv
// ============================================================================
// cd_edge_sync : synchronises clkin and emits a 1-cycle pulse per transition
// Revision 1.0
// ============================================================================
`default_nettype none

module cd_edge_sync
  import cd_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = CD_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic clkin,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
      sync_d     <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], clkin};
      sync_d     <= sync_chain[SYNC_STAGES-1];
    end
  end

  // Both polarities count: the divider output toggles once per half-period.
  assign edge_det = sync_chain[SYNC_STAGES-1] ^ sync_d;

endmodule

`default_nettype wire

// File: rtl/cd_period_meter.sv
// ============================================================================
// cd_period_meter : recovers the divider half-period (limit) of clkin in clk cycles
// Revision 1.0
// ============================================================================
`default_nettype none

module cd_period_meter
  import cd_period_meter_pkg::*;
#(
  parameter int               WIDTH       = CLK_MAX_WIDTH,
  parameter int               SYNC_STAGES = CD_SYNC_STAGES,
  parameter logic [WIDTH-1:0] TIMEOUT     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkin,
  input  logic             start,
  input  logic             meas_ack,
  output logic             busy,
  output logic             meas_valid,
  output logic [WIDTH-1:0] meas_limit,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_LAST = TIMEOUT - CNT_ONE;

  cd_state_e        state;
  logic [WIDTH-1:0] cnt;
  logic             arm_first;
  logic             edge_det;

  cd_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .clkin   (clkin),
    .edge_det(edge_det)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      arm_first  <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      meas_limit <= '0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            cnt       <= '0;
            arm_first <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ARM: begin
          arm_first <= 1'b0;
          // The entry cycle may still see stale synchroniser history, so its edge is dropped.
          if (edge_det && !arm_first) begin
            state <= MEASURE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            timeout    <= 1'b1;
            meas_limit <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            state      <= DONE;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            meas_limit <= cnt + CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            meas_valid <= 1'b1;
            timeout    <= 1'b1;
            meas_limit <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          if (meas_ack) begin
            meas_valid <= 1'b0;
            if (start) begin
              state     <= ARM;
              cnt       <= '0;
              arm_first <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
